// File: rtl/exmem_rcache.sv
// Direct-mapped, write-through, no-write-allocate read cache in front of the user-area memory controller.
// state  | meaning: IDLE lookup/issue, MEM_RD miss fill wait, MEM_WR write-through wait, RESP ack cycle
module exmem_rcache #(
   parameter logic [7:0] ADR_HI  = 8'h38,
   parameter int         IDX_W   = 4,
   parameter int         TIMEOUT = 64
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        mem_valid_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_adr_o,
   output logic [31:0] mem_dat_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_dat_i,
   input  logic        flush_i,
   output logic        timeout_o,
   output logic [15:0] hit_cnt_o,
   output logic [15:0] miss_cnt_o
);
   localparam int LINES = 2**IDX_W;
   localparam int TAG_W = 22 - IDX_W;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, RESP} state_t;
   state_t state, state_nxt;

   logic [LINES-1:0] valid, valid_nxt;
   logic [TAG_W-1:0] tag_arr [LINES];
   logic [31:0]      data_arr [LINES];

   logic             req, hit, fill_en, merge_en, go_idle;
   logic             abort, abort_nxt, flush_pend, flush_pend_nxt;
   logic [IDX_W-1:0] idx, mem_idx;
   logic [TAG_W-1:0] tag, mem_tag;
   logic [WD_W-1:0]  wd, wd_nxt;
   logic             ack_nxt, mem_valid_nxt, mem_we_nxt, timeout_nxt;
   logic [31:0]      dat_nxt, mem_adr_nxt, mem_dat_nxt;
   logic [3:0]       mem_sel_nxt;
   logic [15:0]      hit_cnt_nxt, miss_cnt_nxt;

   assign idx     = wbs_adr_i[IDX_W+1:2];
   assign tag     = wbs_adr_i[23:IDX_W+2];
   assign mem_idx = mem_adr_o[IDX_W+1:2];
   assign mem_tag = mem_adr_o[23:IDX_W+2];
   assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == ADR_HI);
   // a flush in the lookup cycle forces a miss
   assign hit     = valid[idx] & (tag_arr[idx] == tag) & ~flush_i;

   always_comb begin
      state_nxt      = state;
      valid_nxt      = valid;
      ack_nxt        = 1'b0;
      dat_nxt        = '0;
      mem_valid_nxt  = mem_valid_o;
      mem_we_nxt     = mem_we_o;
      mem_sel_nxt    = mem_sel_o;
      mem_adr_nxt    = mem_adr_o;
      mem_dat_nxt    = mem_dat_o;
      timeout_nxt    = timeout_o;
      hit_cnt_nxt    = hit_cnt_o;
      miss_cnt_nxt   = miss_cnt_o;
      wd_nxt         = wd;
      abort_nxt      = abort | ~(wbs_cyc_i & wbs_stb_i);
      flush_pend_nxt = flush_pend | flush_i;
      fill_en        = 1'b0;
      merge_en       = 1'b0;
      go_idle        = 1'b0;
      case (state)
         IDLE: begin
            flush_pend_nxt = 1'b0;
            abort_nxt      = 1'b0;
            if (flush_i) begin
               valid_nxt   = '0;
               timeout_nxt = 1'b0;
            end
            if (req) begin
               wd_nxt      = WD_W'(TIMEOUT - 1);
               mem_adr_nxt = wbs_adr_i;
               if (!wbs_we_i && hit) begin
                  ack_nxt   = 1'b1;
                  dat_nxt   = data_arr[idx];
                  state_nxt = RESP;
                  if (hit_cnt_o != 16'hFFFF) hit_cnt_nxt = hit_cnt_o + 16'd1;
               end else if (!wbs_we_i) begin
                  mem_valid_nxt = 1'b1;
                  mem_we_nxt    = 1'b0;
                  mem_sel_nxt   = 4'hF;
                  mem_dat_nxt   = '0;
                  state_nxt     = MEM_RD;
                  if (miss_cnt_o != 16'hFFFF) miss_cnt_nxt = miss_cnt_o + 16'd1;
               end else begin
                  mem_valid_nxt = 1'b1;
                  mem_we_nxt    = 1'b1;
                  mem_sel_nxt   = wbs_sel_i;
                  mem_dat_nxt   = wbs_dat_i;
                  merge_en      = hit;
                  state_nxt     = MEM_WR;
               end
            end
         end
         MEM_RD, MEM_WR: begin
            if (mem_ack_i) begin
               mem_valid_nxt = 1'b0;
               fill_en       = (state == MEM_RD) & ~flush_pend_nxt;
               if (fill_en) valid_nxt[mem_idx] = 1'b1;
               dat_nxt = (state == MEM_RD) ? mem_dat_i : 32'h0;
            end else if (wd == '0) begin
               mem_valid_nxt = 1'b0;
               timeout_nxt   = 1'b1;
               dat_nxt       = (state == MEM_RD) ? 32'hDEAD_BEEF : 32'h0;
            end else begin
               wd_nxt = wd - 1'b1;
            end
            if (mem_ack_i || wd == '0) begin
               if (abort_nxt) begin
                  dat_nxt   = '0;
                  go_idle   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ack_nxt   = 1'b1;
                  state_nxt = RESP;
               end
            end
         end
         RESP: begin
            go_idle   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // flushes seen while busy take effect as the FSM returns to IDLE
      if (go_idle && flush_pend_nxt) begin
         valid_nxt      = '0;
         timeout_nxt    = 1'b0;
         flush_pend_nxt = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state       <= IDLE;
         valid       <= '0;
         wbs_ack_o   <= 1'b0;
         wbs_dat_o   <= '0;
         mem_valid_o <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_sel_o   <= '0;
         mem_adr_o   <= '0;
         mem_dat_o   <= '0;
         timeout_o   <= 1'b0;
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
         wd          <= '0;
         abort       <= 1'b0;
         flush_pend  <= 1'b0;
      end else begin
         state       <= state_nxt;
         valid       <= valid_nxt;
         wbs_ack_o   <= ack_nxt;
         wbs_dat_o   <= dat_nxt;
         mem_valid_o <= mem_valid_nxt;
         mem_we_o    <= mem_we_nxt;
         mem_sel_o   <= mem_sel_nxt;
         mem_adr_o   <= mem_adr_nxt;
         mem_dat_o   <= mem_dat_nxt;
         timeout_o   <= timeout_nxt;
         hit_cnt_o   <= hit_cnt_nxt;
         miss_cnt_o  <= miss_cnt_nxt;
         wd          <= wd_nxt;
         abort       <= abort_nxt;
         flush_pend  <= flush_pend_nxt;
      end
   end

   // tag/data storage has no reset; the valid bits qualify it
   always_ff @(posedge wb_clk_i) begin
      if (fill_en) begin
         tag_arr[mem_idx]  <= mem_tag;
         data_arr[mem_idx] <= mem_dat_i;
      end
      if (merge_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) data_arr[idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_exmem_rcache.sv
// Bench for exmem_rcache: directed and random accesses against a word-addressed memory and line-ownership model.
module tb_exmem_rcache;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = '0;
   logic [31:0] adr = '0, dat = '0;
   logic        ack;
   logic [31:0] dat_o;
   logic        mem_valid, mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_adr, mem_dat;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdat = '0;
   logic        flush = 1'b0;
   logic        timeout;
   logic [15:0] hit_cnt, miss_cnt;

   int          total = 0;
   int          passed = 0;
   logic [31:0] mem_model [logic [31:0]];
   bit          cv [16];
   logic [29:0] caddr [16];
   logic [15:0] exp_hit = '0, exp_miss = '0;
   logic        exp_to = 1'b0;
   logic [31:0] last_rdata = '0;

   always #5 clk = ~clk;

   exmem_rcache #(.ADR_HI(8'h38), .IDX_W(4), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .mem_valid_o(mem_valid), .mem_we_o(mem_we), .mem_sel_o(mem_sel),
      .mem_adr_o(mem_adr), .mem_dat_o(mem_dat), .mem_ack_i(mem_ack), .mem_dat_i(mem_rdat),
      .flush_i(flush), .timeout_o(timeout), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (mem_model.exists(w)) return mem_model[w];
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic void clear_lines();
      for (int i = 0; i < 16; i++) cv[i] = 1'b0;
   endfunction

   // one master access; memory side answers after lat cycles of mem_valid
   task automatic run(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input int lat, input int flush_at, input int abort_at);
      logic acked, saw_mv, mv_we, in_win, hit, to;
      logic [3:0] mv_sel;
      logic [31:0] mv_adr, mv_dat, rdata, nd;
      int cyc_n, k, max_n, li;
      in_win = (a[31:24] == 8'h38);
      li = int'(a[5:2]);
      if (flush_at == 0) begin clear_lines(); exp_to = 1'b0; end
      hit = cv[li] && (caddr[li] == a[31:2]);
      to = (lat > TIMEOUT);
      max_n = (!in_win || abort_at > 0) ? 24 : 200;
      acked = 0; saw_mv = 0; mv_we = 0; mv_sel = 0; mv_adr = 0; mv_dat = 0; rdata = 0;
      cyc_n = 0; k = 0;
      @(negedge clk);
      mem_ack = 0; cyc = 1; stb = 1; we = w; sel = s; adr = a; dat = d; flush = (flush_at == 0);
      for (int n = 1; n <= max_n; n++) begin
         @(negedge clk);
         mem_ack = 0; flush = 0;
         if (n == abort_at) begin cyc = 0; stb = 0; end
         if (n == flush_at) flush = 1;
         if (ack && !acked) begin
            acked = 1; rdata = dat_o; cyc_n = n; cyc = 0; stb = 0;
         end
         if (mem_valid) begin
            if (!saw_mv) begin
               saw_mv = 1; mv_we = mem_we; mv_sel = mem_sel; mv_adr = mem_adr; mv_dat = mem_dat;
            end
            k++;
            if (k == lat) begin
               mem_ack = 1;
               if (mem_we) begin
                  nd = mem_rd(mem_adr);
                  for (int b = 0; b < 4; b++) if (mem_sel[b]) nd[8*b +: 8] = mem_dat[8*b +: 8];
                  mem_model[{mem_adr[31:2], 2'b00}] = nd;
               end else begin
                  mem_rdat = mem_rd(mem_adr);
               end
            end
         end
         if (acked) break;
      end
      cyc = 0; stb = 0;
      last_rdata = rdata;
      if (!in_win) begin
         check("oow_ack", 32'(acked), 32'd0);
         check("oow_mem_valid", 32'(saw_mv), 32'd0);
      end else if (!w && hit) begin
         exp_hit = sat(exp_hit);
         check("hit_ack", 32'(acked), 32'd1);
         check("hit_latency", 32'(cyc_n), 32'd1);
         check("hit_data", rdata, mem_rd(a));
         check("hit_no_mem_valid", 32'(saw_mv), 32'd0);
      end else begin
         if (!w) exp_miss = sat(exp_miss);
         check("mem_issue", 32'(saw_mv), 32'd1);
         check("mem_we", 32'(mv_we), 32'(w));
         check("mem_sel", 32'(mv_sel), w ? 32'(s) : 32'hF);
         check("mem_adr", mv_adr, a);
         if (w) check("mem_dat", mv_dat, d);
         if (abort_at > 0) begin
            check("abort_no_ack", 32'(acked), 32'd0);
         end else begin
            check("ack", 32'(acked), 32'd1);
            check("latency", 32'(cyc_n), to ? 32'(TIMEOUT + 1) : 32'(lat + 1));
            check("rdata", rdata, w ? 32'h0 : (to ? 32'hDEAD_BEEF : mem_rd(a)));
         end
         if (to) exp_to = 1'b1;
         else if (!w) begin cv[li] = 1'b1; caddr[li] = a[31:2]; end
         if (flush_at > 0) begin clear_lines(); exp_to = 1'b0; end
      end
      check("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
      check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
      check("timeout", 32'(timeout), 32'(exp_to));
   endtask

   task automatic flush_idle();
      @(negedge clk); flush = 1;
      @(negedge clk); flush = 0;
      clear_lines(); exp_to = 1'b0;
      check("flush_clears_timeout", 32'(timeout), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1);
   end

   initial begin
      logic w;
      logic [31:0] a;
      clear_lines();
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat", dat_o, 32'd0);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_counts", {hit_cnt, miss_cnt}, 32'd0);
      rst_n = 1;

      mem_model[32'h3800_0010] = 32'h1234_5678;
      run(0, 32'h3800_0010, 4'hF, 0, 11, -1, -1);
      check("cold_read_data", last_rdata, 32'h1234_5678);
      run(0, 32'h3800_0010, 4'hF, 0, 3, -1, -1);
      run(1, 32'h3800_0010, 4'b0011, 32'hAAAA_BBBB, 3, -1, -1);
      run(0, 32'h3800_0010, 4'hF, 0, 3, -1, -1);
      check("merged_hit_data", last_rdata, 32'h1234_BBBB);
      run(0, 32'h3800_0050, 4'hF, 0, 4, -1, -1);
      run(0, 32'h3800_0010, 4'hF, 0, 4, -1, -1);

      run(0, 32'h3800_0100, 4'hF, 0, 1000, -1, -1);
      flush_idle();
      run(0, 32'h3800_0010, 4'hF, 0, 2, -1, -1);
      run(0, 32'h3800_0200, 4'hF, 0, TIMEOUT, -1, -1);

      run(0, 32'h3000_0000, 4'hF, 0, 2, -1, -1);
      run(1, 32'h3000_0004, 4'hF, 32'h1111_2222, 2, -1, -1);
      @(negedge clk); mem_ack = 1; mem_rdat = 32'hCAFE_F00D;
      @(negedge clk); mem_ack = 0;
      check("stray_ack_ignored", {31'd0, ack}, 32'd0);

      run(0, 32'h3800_0300, 4'hF, 0, 6, 3, -1);
      run(0, 32'h3800_0300, 4'hF, 0, 2, -1, -1);
      run(0, 32'h3800_0300, 4'hF, 0, 2, 0, -1);
      run(0, 32'h3800_0400, 4'hF, 0, 5, -1, 2);
      run(0, 32'h3800_0400, 4'hF, 0, 5, -1, -1);

      for (int i = 0; i < 40; i++) begin
         w = ($urandom_range(0, 3) == 0);
         a = 32'h3800_0000 | (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 9) == 0) a = 32'h3900_0000 | (a & 32'h0000_00FC);
         run(w, a, w ? 4'($urandom_range(1, 15)) : 4'hF, $urandom, $urandom_range(1, 8), -1, -1);
      end

      flush_idle();
      @(negedge clk); cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3800_0600;
      repeat (3) @(negedge clk);
      check("pre_reset_mem_valid", {31'd0, mem_valid}, 32'd1);
      rst_n = 0;
      #1;
      check("async_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("async_rst_ack", {31'd0, ack}, 32'd0);
      check("async_rst_counts", {hit_cnt, miss_cnt}, 32'd0);
      cyc = 0; stb = 0;
      @(negedge clk); rst_n = 1;
      exp_hit = '0; exp_miss = '0; exp_to = 1'b0; clear_lines();
      run(0, 32'h3800_0600, 4'hF, 0, 2, -1, -1);
      run(0, 32'h3800_0600, 4'hF, 0, 2, -1, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
